// File: rtl/cache_fill_fsm.sv
// Cache miss fill FSM: streams one block from main memory into the cache data array, then writes the tag.
// Build option: define CRITICAL_WORD_FIRST_EN to fetch the missing word first and wrap around the block.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] data_array_addr,
  output logic [DATA_W-1:0] data_array_word,
  output logic              write_tag_array
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] WORDS = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic [IDX_W-1:0]  issue_word;
  logic [IDX_W-1:0]  rcv_word;

  // Base has its offset bits cleared, so OR-ing in the word offset can never carry into the tag.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [IDX_W-1:0]  w);
    return b | ADDR_W'({w, 1'b0});
  endfunction

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] start;
  logic             unused_byte_sel;

  assign unused_byte_sel = miss_address[0];
  assign issue_word      = start + issue_cnt[IDX_W-1:0];
  assign rcv_word        = start + rcv_cnt[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      start <= '0;
    end else if (state == IDLE && miss_detected) begin
      start <= miss_address[IDX_W:1];
    end
  end
`else
  logic unused_offset;

  assign unused_offset = ^miss_address[OFF_W-1:0];
  assign issue_word    = issue_cnt[IDX_W-1:0];
  assign rcv_word      = rcv_cnt[IDX_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (miss_detected) begin
          base      <= {miss_address[ADDR_W-1:OFF_W], OFF_W'(0)};
          issue_cnt <= '0;
          rcv_cnt   <= '0;
        end
      end else begin
        if (issue_cnt < WORDS) issue_cnt <= issue_cnt + CNT_W'(1);
        if (memory_data_valid) rcv_cnt <= rcv_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (miss_detected) state_nxt = FILL;
      FILL: if (memory_data_valid && rcv_cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue and receive sides run independently inside FILL; returns arrive in issue order.
  always_comb begin
    fsm_busy         = 1'b0;
    memory_read_en   = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_array_addr  = '0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: fsm_busy = miss_detected;
      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt < WORDS) begin
          memory_read_en = 1'b1;
          memory_address = word_addr(base, issue_word);
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_array_addr  = word_addr(base, rcv_word);
          write_tag_array  = (rcv_cnt == LAST);
        end
      end
      default: fsm_busy = 1'b0;
    endcase
  end

  assign data_array_word = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: in-order memory model with configurable gaps and a block-order reference.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] data_array_addr;
  logic [15:0] data_array_word;
  logic        write_tag_array;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] q_addr[$];
  logic [15:0] q_data[$];
  int          q_due[$];

  localparam int LAT = 4;

  always #5 clk = ~clk;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .memory_read_en(memory_read_en), .memory_address(memory_address),
    .write_data_array(write_data_array), .data_array_addr(data_array_addr),
    .data_array_word(data_array_word), .write_tag_array(write_tag_array)
  );

  // One miss from the miss cycle up to the tag write (or an abort by reset after rst_after writes).
  task automatic run_fill(input logic [15:0] maddr, input int gapmax, input bit mid_miss,
                          input int rst_after, input bit check_idle);
    logic [15:0] seq[8];
    logic [15:0] base;
    int start, issued, rcvd, c, gap_left;
    bit done, do_rst, aborted;
    logic v;
    base = maddr & 16'hFFF0;
`ifdef CRITICAL_WORD_FIRST_EN
    start = int'(maddr[3:1]);
`else
    start = 0;
`endif
    for (int i = 0; i < 8; i++) seq[i] = base + 16'(2 * ((start + i) % 8));

    @(posedge clk); #1;
    rst = 1'b0; miss_detected = 1'b1; miss_address = maddr; memory_data_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (fsm_busy !== 1'b1) begin
      miscompares++; $display("FAIL busy_in_miss_cycle addr=%h: got %b expected 1", maddr, fsm_busy);
    end
    vectors++;
    if ({memory_read_en, write_data_array, write_tag_array} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_outputs addr=%h: got %b expected 000", maddr,
               {memory_read_en, write_data_array, write_tag_array});
    end

    issued = 0; rcvd = 0; c = 0; gap_left = 0; done = 0; do_rst = 0; aborted = 0;
    while (!done) begin
      c++;
      @(posedge clk); #1;
      miss_detected = mid_miss && (c == 5);
      miss_address  = (mid_miss && c == 5) ? 16'h5000 : maddr;
      rst = do_rst;
      v = (q_addr.size() > 0) && (q_due[0] <= c) && (gap_left == 0);
      if (!v && gap_left > 0) gap_left--;
      memory_data_valid = v;
      memory_data = v ? q_data[0] : 16'($urandom);
      @(negedge clk);
      if (!do_rst) begin
        vectors++;
        if (fsm_busy !== 1'b1) begin
          miscompares++; $display("FAIL busy_during_fill c=%0d: got %b expected 1", c, fsm_busy);
        end
        vectors++;
        if (memory_read_en !== (issued < 8)) begin
          miscompares++;
          $display("FAIL read_en c=%0d: got %b expected %b", c, memory_read_en, (issued < 8));
        end
        if (issued < 8) begin
          vectors++;
          if (memory_address !== seq[issued]) begin
            miscompares++;
            $display("FAIL read_addr #%0d: got %h expected %h", issued, memory_address, seq[issued]);
          end
        end
        vectors++;
        if (write_data_array !== v) begin
          miscompares++; $display("FAIL write_data c=%0d: got %b expected %b", c, write_data_array, v);
        end
        if (v) begin
          vectors++;
          if (data_array_addr !== seq[rcvd]) begin
            miscompares++;
            $display("FAIL write_addr #%0d: got %h expected %h", rcvd, data_array_addr, seq[rcvd]);
          end
          vectors++;
          if (data_array_word !== q_data[0]) begin
            miscompares++;
            $display("FAIL write_word #%0d: got %h expected %h", rcvd, data_array_word, q_data[0]);
          end
        end
        vectors++;
        if (write_tag_array !== (v && rcvd == 7)) begin
          miscompares++;
          $display("FAIL tag_write c=%0d: got %b expected %b", c, write_tag_array, (v && rcvd == 7));
        end
      end
      if (issued < 8) begin
        q_addr.push_back(seq[issued]);
        q_data.push_back(16'hA000 + {12'h0, seq[issued][3:0]});
        q_due.push_back(c + LAT - 1);
        issued++;
      end
      if (v) begin
        void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_due.pop_front());
        rcvd++;
        gap_left = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      end
      if (do_rst) begin
        aborted = 1; done = 1;
      end else if (rcvd == 8) begin
        done = 1;
      end else if (rst_after > 0 && rcvd == rst_after) begin
        do_rst = 1;
      end
      if (!done && c > 80) begin
        miscompares++; $display("FAIL fill_timeout addr=%h: got %0d writes expected 8", maddr, rcvd);
        done = 1;
      end
    end

    if (aborted) begin
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        rst = 1'b0; miss_detected = 1'b0;
        v = (q_addr.size() > 0);
        memory_data_valid = v;
        memory_data = v ? q_data[0] : 16'h0;
        @(negedge clk);
        vectors++;
        if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0000) begin
          miscompares++;
          $display("FAIL after_reset k=%0d: got %b expected 0000", k,
                   {fsm_busy, memory_read_en, write_data_array, write_tag_array});
        end
        if (v) begin
          void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_due.pop_front());
        end
      end
      memory_data_valid = 1'b0;
    end else begin
      if (gapmax == 0) begin
        vectors++;
        if (c + 1 != 1 + 8 + LAT - 1) begin
          miscompares++;
          $display("FAIL busy_length addr=%h: got %0d expected %0d", maddr, c + 1, 1 + 8 + LAT - 1);
        end
      end
      if (check_idle) begin
        @(posedge clk); #1;
        miss_detected = 1'b0; memory_data_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({fsm_busy, memory_read_en, write_tag_array} !== 3'b000) begin
          miscompares++;
          $display("FAIL idle_after_fill addr=%h: got %b expected 000", maddr,
                   {fsm_busy, memory_read_en, write_tag_array});
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data = 16'h0; memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {fsm_busy, memory_read_en, write_data_array, write_tag_array});
    end
    vectors++;
    if ({memory_address, data_array_addr} !== 32'h0) begin
      miscompares++; $display("FAIL reset_addrs: got %h/%h expected 0/0", memory_address, data_array_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; memory_data_valid = 1'b1; memory_data = 16'h5A5A;
    @(negedge clk);
    vectors++;
    if ({fsm_busy, write_data_array, write_tag_array} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_ignores_valid: got %b expected 000", {fsm_busy, write_data_array, write_tag_array});
    end
    vectors++;
    if (data_array_word !== 16'h5A5A) begin
      miscompares++; $display("FAIL word_passthrough: got %h expected 5a5a", data_array_word);
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_basic_fill();
    run_fill(16'h1234, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_miss_ignored_back_to_back();
    run_fill(16'h1234, 0, 1'b1, 0, 1'b0);
    run_fill(16'h5000, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    run_fill(16'h2468, 0, 1'b0, 3, 1'b0);
    run_fill(16'h0102, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_top_of_memory();
    run_fill(16'hFFFF, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_stalled_memory();
    run_fill(16'h0ABC, 3, 1'b0, 0, 1'b1);
  endtask

  task automatic test_critical_word_order();
    run_fill(16'h123A, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_random_fills();
    for (int n = 0; n < 8; n++)
      run_fill(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 0, 1'($urandom));
    run_fill(16'h3000, 0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_fill();
    test_miss_ignored_back_to_back();
    test_reset_mid_fill();
    test_top_of_memory();
    test_stalled_memory();
    test_critical_word_order();
    test_random_fills();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling FSM between the pipeline's cache tag/data arrays and the shared multi-cycle main memory.
- The fetch stage (I-cache miss) or the memory stage (D-cache miss) raises a miss, and this block stalls the pipeline via fsm_busy.
- It streams one 8-word (16-byte) block from memory, writes each returned word into the data array, and writes the tag on the last word.
- One instance is used per cache; the I- and D-cache instances are arbitrated outside this block.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; power of 2; each word is 2 bytes.
- ADDR_W, 16, byte-address width.
- DATA_W, 16, memory word width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache miss this cycle; sampled only in IDLE.
- miss_address  in  ADDR_W  byte address of the missing access.
- memory_data  in  DATA_W  word returned by main memory.
- memory_data_valid  in  1  memory_data is valid this cycle; returns arrive in issue order.
- fsm_busy  out  1  stall request to the pipeline.
- memory_read_en  out  1  issue one memory read this cycle.
- memory_address  out  ADDR_W  address of the read being issued.
- write_data_array  out  1  write data_array_word into the cache data array this cycle.
- data_array_addr  out  ADDR_W  byte address of the word being written.
- data_array_word  out  DATA_W  combinational pass-through of memory_data.
- write_tag_array  out  1  write tag and valid bit for the block; one-cycle pulse.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high; ports are named clk and rst.
- State:
  - 1-bit state, IDLE or FILL.
  - Registers: base (ADDR_W), issue_cnt (log2(WORDS)+1 bits), rcv_cnt (log2(WORDS)+1 bits).
- Reset:
  - state=IDLE; base, issue_cnt and rcv_cnt = 0.
  - All outputs 0 except data_array_word, which is pass-through.
  - Reset mid-FILL aborts the fill immediately. No tag write occurs, and late memory returns are ignored because the FSM is back in IDLE.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the pipeline stalls in the miss cycle itself).
  - memory_read_en, write_data_array and write_tag_array are 0.
  - memory_data_valid is ignored.
  - On miss_detected: base <= miss_address with the low log2(WORDS*2) bits cleared; issue_cnt and rcv_cnt <= 0; state <= FILL.
- FILL:
  - fsm_busy = 1.
  - Issue: memory_read_en = (issue_cnt < WORDS). memory_address = base + 2*word(issue_cnt). issue_cnt increments each cycle while below WORDS, giving one read per cycle for WORDS consecutive cycles.
  - Receive: when memory_data_valid, write_data_array = 1, data_array_addr = base + 2*word(rcv_cnt), and rcv_cnt increments.
  - Finish: write_tag_array = memory_data_valid && (rcv_cnt == WORDS-1), in the same cycle as the last data write. Next state is IDLE, so fsm_busy drops the following cycle.
  - Issue and receive are independent and may occur in the same cycle.
  - miss_detected is ignored.
- word(i) = i by default; see the Optional Feature for the alternative ordering.
- Address arithmetic:
  - Offsets stay within the block and never carry into tag bits.
  - base 0xFFF0 covers 0xFFF0..0xFFFE with no wrap beyond ADDR_W.
- Latency: with memory latency L, fill length is 1 + WORDS + L - 1 cycles from the miss cycle. For L=4 this is 12 busy cycles including the miss cycle.
- Back-to-back misses: a new miss is accepted in the first IDLE cycle after write_tag_array.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - start = miss_address[log2(WORDS):1] is latched in IDLE.
  - word(i) = (start + i) mod WORDS for both issue and receive ordering, so the missing word is requested and written first.
  - write_tag_array still fires on the WORDS-th return.
- Undefined: word(i) = i, with strictly ascending order from base.

Test Plan:
- Basic fill:
  - Stimulus: rst 2 cycles, miss_detected=1 with miss_address=0x1234 for 1 cycle; memory model L=4 returns 0xA000+offset.
  - Response: reads issued to 0x1230,0x1232,...,0x123E on 8 consecutive cycles. Data writes to the same addresses with matching data. write_tag_array is a single pulse on the 8th write. fsm_busy high for 12 cycles, then 0.
- Miss ignored while filling:
  - Stimulus: during the fill above, assert miss_detected with 0x5000 mid-fill.
  - Response: no read to 0x5000 and base unchanged. A second miss at 0x5000, one cycle after write_tag_array, starts a new fill at 0x5000.
- Reset mid-fill:
  - Stimulus: assert rst after the 3rd data write.
  - Response: all outputs 0 the next cycle, no write_tag_array, and the remaining memory_data_valid pulses produce no write_data_array.
- Top-of-memory block:
  - Stimulus: miss at 0xFFFF.
  - Response: base 0xFFF0, reads to 0xFFF0..0xFFFE, no address wrap to 0x0000.
- Stalled memory:
  - Stimulus: memory returns the 8 words with random gaps (valid held low 0–3 cycles between returns).
  - Response: exactly 8 data writes in address order. write_tag_array fires only with the 8th. fsm_busy stays high throughout.
- With CRITICAL_WORD_FIRST_EN:
  - Stimulus: miss at 0x123A.
  - Response: reads and writes in order 0x123A,0x123C,0x123E,0x1230,...,0x1238. Tag write on the return for 0x1238.
